prog_launch_ctrl: RTL

//  Program-launch sequencer between the bench/host req/ack handshake and the CPU core.

---
 rtl/prog_launch_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/prog_launch_ctrl.sv
// Program-launch sequencer between the host req/ack handshake and the CPU core.
// Each accepted req loads the next program's start PC and runs the core until it halts or the watchdog expires.
//
// Ports:
//   clk       in   system clock, all state on rising edge
//   reset     in   asynchronous active-high reset
//   req       in   launch next program (accepted in IDLE/DONE only)
//   halt      in   core executed halt (observed in RUN only)
//   ack       out  program finished; level until next accepted req
//   run       out  core execute permit
//   pc_load   out  one-cycle strobe: PC <= pc_start
//   pc_start  out  start address of program prog_id
//   prog_id   out  index of program being / last launched
//   timeout   out  sticky: last program ended by watchdog
//   cycles    out  run-cycle count (only with PROG_CYCLE_CNT_EN)
//
// Build option: define PROG_CYCLE_CNT_EN to add the cycles counter/port.
module prog_launch_ctrl #(
    parameter int AW     = 8,
    parameter int NPROG  = 3,
    parameter int START0 = 0,
    parameter int START1 = 64,
    parameter int START2 = 128,
    parameter int WDT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          halt,
    output logic          ack,
    output logic          run,
    output logic          pc_load,
    output logic [AW-1:0] pc_start,
    output logic [1:0]    prog_id,
    output logic          timeout
`ifdef PROG_CYCLE_CNT_EN
    ,
    output logic [31:0]   cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0]       LAST_ID = 2'(NPROG - 1);
    localparam logic [WDT_W-1:0] WDT_ONE = WDT_W'(1);

    state_t           state_q, state_d;
    logic             launch, advance, to_set, wdt_hit;
    logic [1:0]       prog_id_q, prog_id_d;
    logic [AW-1:0]    pc_start_q;
    logic [WDT_W-1:0] wdt_q, wdt_inc;
    logic             timeout_q;

    function automatic logic [AW-1:0] start_addr(input logic [1:0] id);
        case (id)
            2'd1:    return AW'(START1);
            2'd2:    return AW'(START2);
            default: return AW'(START0);
        endcase
    endfunction

    // wdt_q counts completed run cycles; the cycle whose increment
    // reaches all-ones is the last one allowed (2**WDT_W-1 run cycles).
    assign wdt_inc = wdt_q + WDT_ONE;
    assign wdt_hit = (wdt_inc == '1);

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        advance = 1'b0;
        to_set  = 1'b0;
        ack     = 1'b0;
        run     = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LOAD;
                    launch  = 1'b1;
                end
            end
            S_LOAD: begin
                pc_load = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                run = 1'b1;
                // halt has priority, so a same-cycle expiry is not a timeout
                if (halt) begin
                    state_d = S_DONE;
                end else if (wdt_hit) begin
                    state_d = S_DONE;
                    to_set  = 1'b1;
                end
            end
            S_DONE: begin
                ack = 1'b1;
                if (req) begin
                    state_d = S_LOAD;
                    launch  = 1'b1;
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prog_id_d = prog_id_q;
        if (advance) begin
            prog_id_d = (prog_id_q == LAST_ID) ? 2'd0 : prog_id_q + 2'd1;
        end
    end

    // Launch-time clears happen on the accepting edge so the LOAD
    // cycle already presents clean status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prog_id_q  <= 2'd0;
            pc_start_q <= AW'(START0);
            wdt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prog_id_q <= prog_id_d;
            if (launch) begin
                pc_start_q <= start_addr(prog_id_d);
            end
            if (launch) begin
                wdt_q <= '0;
            end else if (run) begin
                wdt_q <= wdt_inc;
            end
            if (launch) begin
                timeout_q <= 1'b0;
            end else if (to_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign pc_start = pc_start_q;
    assign prog_id  = prog_id_q;
    assign timeout  = timeout_q;

`ifdef PROG_CYCLE_CNT_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
        end else if (launch) begin
            cycles_q <= '0;
        end else if (run && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule
